// File: rtl/bcd_accumulator_pkg.sv
// Shared constants, FSM encoding and helpers for the BCD accumulator.
package bcd_accumulator_pkg;

    localparam int unsigned NIBBLE_W  = 4;
    localparam int unsigned OPERAND_W = 8;

    // Largest legal BCD digit and the correction added when a digit sum exceeds it
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_ADJ = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    // True when the nibble is a legal BCD digit
    function automatic logic is_bcd(input logic [3:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage : bcd_accumulator_pkg

// File: rtl/bcd_accumulator_if.sv
// Request/result bundle between a controller (master) and the accumulator (slave).
//   Start   : add request, level, rising edge detected in the slave
//   Clear   : clears total and flags
//   Operand : two BCD digits, [7:4] tens, [3:0] units
//   Acc     : BCD total, [3:0] units digit upward
//   Busy/Done/Ovf/Err : status back to the master
interface bcd_accumulator_if #(
    parameter int unsigned DIGITS = 3
);
    import bcd_accumulator_pkg::*;

    localparam int unsigned ACC_W = NIBBLE_W * DIGITS;

    logic                 Start;
    logic                 Clear;
    logic [OPERAND_W-1:0] Operand;
    logic [ACC_W-1:0]     Acc;
    logic                 Busy;
    logic                 Done;
    logic                 Ovf;
    logic                 Err;

    modport master (
        output Start, Clear, Operand,
        input  Acc, Busy, Done, Ovf, Err
    );

    modport slave (
        input  Start, Clear, Operand,
        output Acc, Busy, Done, Ovf, Err
    );

endinterface : bcd_accumulator_if

// File: rtl/bcd_accumulator_digit_adder.sv
// Single-digit BCD adder: s_o/co_o = a_i + b_i + ci_i with decimal correction.
//   a_i, b_i : BCD digits (0..9)
//   ci_i     : carry in
//   s_o      : BCD sum digit
//   co_o     : decimal carry out
module bcd_digit_adder
    import bcd_accumulator_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       ci_i,
    output logic [3:0] s_o,
    output logic       co_o
);

    logic [4:0] bin_sum;

    always_comb begin
        bin_sum = 5'(a_i) + 5'(b_i) + 5'(ci_i);
        s_o     = bin_sum[3:0];
        co_o    = 1'b0;
        // Above 9 the +6 skips the six unused codes; the low nibble wraps to the BCD digit
        if (bin_sum > {1'b0, BCD_MAX}) begin
            s_o  = 4'(bin_sum[3:0] + BCD_ADJ);
            co_o = 1'b1;
        end
    end

endmodule : bcd_digit_adder

// File: rtl/bcd_accumulator.sv
// Digit-serial BCD accumulator: adds a two-digit BCD operand into a DIGITS-digit
// running total, one digit per clock, using one time-shared digit adder.
//   Clock : rising-edge clock
//   Reset : synchronous, active-high
//   bus   : slave side of bcd_accumulator_if (Start/Clear/Operand in,
//           Acc/Busy/Done/Ovf/Err out, all outputs registered)
module bcd_accumulator
    import bcd_accumulator_pkg::*;
#(
    parameter int unsigned DIGITS = 3
) (
    input  logic               Clock,
    input  logic               Reset,
    bcd_accumulator_if.slave   bus
);

    localparam int unsigned ACC_W = NIBBLE_W * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 carry_q, carry_d;
    logic [OPERAND_W-1:0] opnd_q, opnd_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;
    logic                 err_q, err_d;
    logic                 start_hist_q, start_hist_d;

    logic                 start_edge;
    logic [3:0]           add_a;
    logic [3:0]           add_b;
    logic [3:0]           add_s;
    logic                 add_co;

    bcd_digit_adder u_digit_adder (
        .a_i  (add_a),
        .b_i  (add_b),
        .ci_i (carry_q),
        .s_o  (add_s),
        .co_o (add_co)
    );

    // Adder operand select: current accumulator digit and operand digit (zero above tens)
    always_comb begin
        add_a = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                add_a = acc_q[NIBBLE_W*i +: NIBBLE_W];
            end
        end
        if (idx_q == IDX_W'(0)) begin
            add_b = opnd_q[3:0];
        end else if (idx_q == IDX_W'(1)) begin
            add_b = opnd_q[7:4];
        end else begin
            add_b = '0;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        carry_d      = carry_q;
        opnd_d       = opnd_q;
        acc_d        = acc_q;
        ovf_d        = ovf_q;
        err_d        = err_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        start_hist_d = bus.Start;

        start_edge   = bus.Start & ~start_hist_q;

        unique case (state_q)
            IDLE: begin
                if (start_edge) begin
                    if (is_bcd(bus.Operand[7:4]) && is_bcd(bus.Operand[3:0])) begin
                        opnd_d  = bus.Operand;
                        idx_d   = '0;
                        carry_d = 1'b0;
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = ADD;
                    end else begin
                        // Rejected request: total untouched, completion still signalled
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end

            ADD: begin
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        acc_d[NIBBLE_W*i +: NIBBLE_W] = add_s;
                    end
                end
                carry_d = add_co;
                if (idx_q == IDX_LAST) begin
                    ovf_d   = ovf_q | add_co;
                    idx_d   = '0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d   = IDX_W'(idx_q + 1'b1);
                    busy_d  = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear aborts anything in flight; the edge history still samples Start,
        // so a coincident Start edge is consumed
        if (bus.Clear) begin
            acc_d   = '0;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
            idx_d   = '0;
            carry_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            state_d = IDLE;
        end
    end

    // State and output registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            carry_q      <= 1'b0;
            opnd_q       <= '0;
            acc_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
            err_q        <= 1'b0;
            start_hist_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            carry_q      <= carry_d;
            opnd_q       <= opnd_d;
            acc_q        <= acc_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
            err_q        <= err_d;
            start_hist_q <= start_hist_d;
        end
    end

    assign bus.Acc  = acc_q;
    assign bus.Busy = busy_q;
    assign bus.Done = done_q;
    assign bus.Ovf  = ovf_q;
    assign bus.Err  = err_q;

endmodule : bcd_accumulator

// File: tb/tb_bcd_accumulator.sv
// Scoreboard bench for bcd_accumulator (DIGITS = 3).
module tb_bcd_accumulator;

    typedef struct packed {
        logic [11:0] acc;
        logic        ovf;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t exp_q[$];

    bcd_accumulator_if #(.DIGITS(3)) bus ();

    bcd_accumulator #(.DIGITS(3)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every Done pulse is matched against the oldest expected result
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.Done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got acc=%h with no request pending", bus.Acc);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_result", {18'd0, bus.Acc, bus.Ovf, bus.Err}, {18'd0, e.acc, e.ovf, e.err});
                end
            end
        end
    end

    // Issue one request, push its result, and check the Busy/Done timing
    task automatic run_op(input logic [7:0] op, input logic [11:0] eacc,
                          input logic eovf, input logic eerr);
        int nbusy;
        int done_at;
        exp_q.push_back('{acc: eacc, ovf: eovf, err: eerr});
        nbusy   = 0;
        done_at = 0;
        @(negedge clk);
        bus.Operand = op;
        bus.Start   = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) bus.Start = 1'b0;
            if (bus.Busy === 1'b1) nbusy++;
            if (bus.Done === 1'b1 && done_at == 0) done_at = c;
        end
        chk("busy_cycles", 32'(nbusy), eerr ? 32'd0 : 32'd3);
        chk("done_latency", 32'(done_at), eerr ? 32'd1 : 32'd4);
    endtask

    task automatic do_clear();
        @(negedge clk);
        bus.Clear = 1'b1;
        @(negedge clk);
        bus.Clear = 1'b0;
        chk("after_clear", {16'd0, bus.Acc, bus.Ovf, bus.Err, bus.Busy, bus.Done}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] ramp [10];
        int          ndone;
        int          nbusy;

        ramp = '{12'h099, 12'h198, 12'h297, 12'h396, 12'h495,
                 12'h594, 12'h693, 12'h792, 12'h891, 12'h990};
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.Start   = 1'b0;
        bus.Clear   = 1'b0;
        bus.Operand = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_state", {16'd0, bus.Acc, bus.Ovf, bus.Err, bus.Busy, bus.Done}, 32'd0);

        // Basic adds, including a carry ripple through two digits
        run_op(8'h45, 12'h045, 1'b0, 1'b0);
        run_op(8'h67, 12'h112, 1'b0, 1'b0);

        // Ramp up to 999 then wrap
        do_clear();
        for (int i = 0; i < 10; i++) run_op(8'h99, ramp[i], 1'b0, 1'b0);
        run_op(8'h09, 12'h999, 1'b0, 1'b0);
        run_op(8'h01, 12'h000, 1'b1, 1'b0);
        run_op(8'h45, 12'h045, 1'b1, 1'b0);
        do_clear();

        // Invalid operand, then a valid one clears Err
        run_op(8'h5A, 12'h000, 1'b0, 1'b1);
        run_op(8'hA3, 12'h000, 1'b0, 1'b1);
        run_op(8'h12, 12'h012, 1'b0, 1'b0);

        // Start held for 10 cycles: exactly one add
        exp_q.push_back('{acc: 12'h013, ovf: 1'b0, err: 1'b0});
        ndone = 0;
        @(negedge clk);
        bus.Operand = 8'h01;
        bus.Start   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.Done === 1'b1) ndone++;
        end
        bus.Start = 1'b0;
        chk("held_start_dones", 32'(ndone), 32'd1);
        chk("held_start_acc", 32'(bus.Acc), 32'h013);

        // Second edge while busy is discarded
        exp_q.push_back('{acc: 12'h014, ovf: 1'b0, err: 1'b0});
        @(negedge clk);
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        @(negedge clk);
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (6) @(negedge clk);
        chk("busy_edge_ignored", 32'(bus.Acc), 32'h014);

        // Reset in the second ADD cycle
        @(negedge clk);
        bus.Operand = 8'h11;
        bus.Start   = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_add_reset", {16'd0, bus.Acc, bus.Ovf, bus.Err, bus.Busy, bus.Done}, 32'd0);
        repeat (5) @(negedge clk);
        chk("post_reset_idle", {16'd0, bus.Acc, bus.Ovf, bus.Err, bus.Busy, bus.Done}, 32'd0);

        // Clear and Start in the same IDLE cycle: Clear wins, no add
        run_op(8'h05, 12'h005, 1'b0, 1'b0);
        @(negedge clk);
        bus.Operand = 8'h01;
        bus.Clear   = 1'b1;
        bus.Start   = 1'b1;
        @(negedge clk);
        bus.Clear = 1'b0;
        ndone = 0;
        nbusy = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.Busy === 1'b1) nbusy++;
            if (bus.Done === 1'b1) ndone++;
            @(negedge clk);
        end
        bus.Start = 1'b0;
        chk("clear_start_busy", 32'(nbusy), 32'd0);
        chk("clear_start_done", 32'(ndone), 32'd0);
        chk("clear_start_acc", 32'(bus.Acc), 32'h000);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bcd_accumulator
